data_cache_ctrl: RTL and testbench

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

---
 rtl/data_cache_ctrl_if.sv | 30 +++
 rtl/data_cache_ctrl.sv | 161 ++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/data_cache_ctrl_if.sv
// Bundles the CPU-side request bus and the main-memory bus of the data cache controller.
// The controller takes the slave side; the CPU plus the memory model take the master side.
interface data_cache_ctrl_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        stall;
    logic        update;
    logic        fill;
    logic [4:0]  index;
    logic [1:0]  offset;
    logic        MsRead;
    logic        MsWrite;
    logic [31:0] MsAddr;
    logic [31:0] MsData_in;
    logic        MsReady;

    modport slave (
        input  MemRead, MemWrite, address, data_in, MsReady,
        output stall, update, fill, index, offset,
        output MsRead, MsWrite, MsAddr, MsData_in
    );

    modport master (
        output MemRead, MemWrite, address, data_in, MsReady,
        input  stall, update, fill, index, offset,
        input  MsRead, MsWrite, MsAddr, MsData_in
    );
endinterface

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Geometry: 32 lines x 4 words; tag = addr[31:9], index = addr[8:4], offset = addr[3:2].
module data_cache_ctrl (
    input  logic               clk_i,
    input  logic               rst_ni,
    data_cache_ctrl_if.slave   bus_io
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        WR_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_data_q, lat_data_d;
    logic [31:0] valid_q;
    logic [22:0] tag_q [32];

    logic [4:0]  req_index;
    logic [22:0] req_tag;
    logic        hit;
    logic        accept_write;
    logic        accept_miss;
    logic        refill;
    logic [31:0] cur_addr;

    assign req_index = bus_io.address[8:4];
    assign req_tag   = bus_io.address[31:9];
    assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);

    // A simultaneous read and write is handled as a write, so a miss needs MemWrite low.
    assign accept_write = (state_q == IDLE) && bus_io.MemWrite;
    assign accept_miss  = (state_q == IDLE) && bus_io.MemRead && !bus_io.MemWrite && !hit;
    assign refill       = (state_q == RD_WAIT) && bus_io.MsReady;
    assign cur_addr     = (state_q == IDLE) ? bus_io.address : lat_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_write) begin
                    state_d = WR_WAIT;
                end else if (accept_miss) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus_io.MsReady) begin
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                if (bus_io.MsReady) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        if (accept_write) begin
            lat_addr_d = bus_io.address;
            lat_data_d = bus_io.data_in;
        end else if (accept_miss) begin
            lat_addr_d = bus_io.address;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_addr_q <= '0;
            lat_data_q <= '0;
        end else begin
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
        end
    end

    // Only a completed line fill installs a line; write misses never allocate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (refill) begin
            valid_q[lat_addr_q[8:4]] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill) begin
            tag_q[lat_addr_q[8:4]] <= lat_addr_q[31:9];
        end
    end

    always_comb begin
        bus_io.stall     = 1'b0;
        bus_io.update    = 1'b0;
        bus_io.fill      = 1'b0;
        bus_io.MsRead    = 1'b0;
        bus_io.MsWrite   = 1'b0;
        bus_io.MsAddr    = '0;
        bus_io.MsData_in = '0;
        bus_io.index     = cur_addr[8:4];
        bus_io.offset    = cur_addr[3:2];
        unique case (state_q)
            IDLE: begin
                bus_io.stall  = accept_write || accept_miss;
                bus_io.update = accept_write && hit;
            end
            RD_WAIT: begin
                bus_io.stall  = 1'b1;
                bus_io.MsRead = 1'b1;
                bus_io.MsAddr = {lat_addr_q[31:4], 4'b0000};
                bus_io.fill   = bus_io.MsReady;
            end
            WR_WAIT: begin
                bus_io.stall     = 1'b1;
                bus_io.MsWrite   = 1'b1;
                bus_io.MsAddr    = lat_addr_q;
                bus_io.MsData_in = lat_data_q;
            end
            WR_DONE: begin
                bus_io.stall = 1'b0;
            end
            default: begin
                bus_io.stall = 1'b0;
            end
        endcase
    end

    // Structural invariants of the strobes towards the data array and main memory.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus_io.update && bus_io.fill));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus_io.MsRead && bus_io.MsWrite));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus_io.fill |-> (state_q == RD_WAIT) && bus_io.MsReady);
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus_io.MsRead && !bus_io.MsReady) |=> bus_io.MsRead);
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus_io.MsWrite && !bus_io.MsReady) |=> bus_io.MsWrite);

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scripted CPU/memory bench for data_cache_ctrl: each driven cycle queues its expected
// outputs, which are popped and compared on the following falling clock edge.
module tb_data_cache_ctrl;

    typedef struct packed {
        logic        stall;
        logic        update;
        logic        fill;
        logic [4:0]  index;
        logic [1:0]  offset;
        logic        msRead;
        logic        msWrite;
        logic [31:0] msAddr;
        logic [31:0] msData;
    } outVec_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;

    data_cache_ctrl_if bus ();

    data_cache_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    outVec_t expQ[$];
    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic outVec_t mkOut(input logic stall, input logic update, input logic fill,
                                      input logic [31:0] idxAddr, input logic msRead,
                                      input logic msWrite, input logic [31:0] msAddr,
                                      input logic [31:0] msData);
        outVec_t v;
        v.stall   = stall;
        v.update  = update;
        v.fill    = fill;
        v.index   = idxAddr[8:4];
        v.offset  = idxAddr[3:2];
        v.msRead  = msRead;
        v.msWrite = msWrite;
        v.msAddr  = msAddr;
        v.msData  = msData;
        return v;
    endfunction

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic ready);
        @(posedge clk);
        #1;
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.address  = addr;
        bus.data_in  = data;
        bus.MsReady  = ready;
    endtask

    task automatic compareCycle(input string name);
        outVec_t e;
        checkOutput({name, ":queued"}, 32'(expQ.size()), 32'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({name, ":stall"},   {31'd0, bus.stall},   {31'd0, e.stall});
            checkOutput({name, ":update"},  {31'd0, bus.update},  {31'd0, e.update});
            checkOutput({name, ":fill"},    {31'd0, bus.fill},    {31'd0, e.fill});
            checkOutput({name, ":index"},   {27'd0, bus.index},   {27'd0, e.index});
            checkOutput({name, ":offset"},  {30'd0, bus.offset},  {30'd0, e.offset});
            checkOutput({name, ":MsRead"},  {31'd0, bus.MsRead},  {31'd0, e.msRead});
            checkOutput({name, ":MsWrite"}, {31'd0, bus.MsWrite}, {31'd0, e.msWrite});
            checkOutput({name, ":MsAddr"},  bus.MsAddr,           e.msAddr);
            checkOutput({name, ":MsData"},  bus.MsData_in,        e.msData);
        end
    endtask

    task automatic sampleCycle(input string name);
        @(negedge clk);
        compareCycle(name);
    endtask

    task automatic idleCycle(input string name, input logic ready);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, ready);
        expQ.push_back(mkOut(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0));
        sampleCycle(name);
    endtask

    // A miss holds the request through RD_WAIT; MsReady arrives on the delay-th wait cycle.
    task automatic doRead(input string name, input logic [31:0] addr, input logic hit,
                          input int delay);
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 1'b0);
        expQ.push_back(mkOut(!hit, 1'b0, 1'b0, addr, 1'b0, 1'b0, 32'h0, 32'h0));
        sampleCycle({name, ":req"});
        if (!hit) begin
            for (int k = 1; k <= delay; k++) begin
                applyStimulus(1'b1, 1'b0, addr, 32'h0, k == delay);
                expQ.push_back(mkOut(1'b1, 1'b0, k == delay, addr, 1'b1, 1'b0,
                                     {addr[31:4], 4'b0000}, 32'h0));
                sampleCycle({name, ":rdwait"});
            end
            applyStimulus(1'b1, 1'b0, addr, 32'h0, 1'b0);
            expQ.push_back(mkOut(1'b0, 1'b0, 1'b0, addr, 1'b0, 1'b0, 32'h0, 32'h0));
            sampleCycle({name, ":rehit"});
        end
        idleCycle({name, ":idle"}, 1'b0);
    endtask

    task automatic doWrite(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic hit, input int delay, input logic alsoRead);
        applyStimulus(alsoRead, 1'b1, addr, data, 1'b0);
        expQ.push_back(mkOut(1'b1, hit, 1'b0, addr, 1'b0, 1'b0, 32'h0, 32'h0));
        sampleCycle({name, ":req"});
        for (int k = 1; k <= delay; k++) begin
            applyStimulus(alsoRead, 1'b1, addr, data, k == delay);
            expQ.push_back(mkOut(1'b1, 1'b0, 1'b0, addr, 1'b0, 1'b1, addr, data));
            sampleCycle({name, ":wrwait"});
        end
        applyStimulus(alsoRead, 1'b1, addr, data, 1'b0);
        expQ.push_back(mkOut(1'b0, 1'b0, 1'b0, addr, 1'b0, 1'b0, 32'h0, 32'h0));
        sampleCycle({name, ":wrdone"});
        idleCycle({name, ":idle"}, 1'b0);
    endtask

    initial begin
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.address  = 32'h0;
        bus.data_in  = 32'h0;
        bus.MsReady  = 1'b0;

        expQ.push_back(mkOut(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0));
        sampleCycle("reset");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        idleCycle("post_reset", 1'b0);

        doRead("cold_read", 32'h0000_0A14, 1'b0, 3);
        doRead("read_hit", 32'h0000_0A14, 1'b1, 0);
        doWrite("write_hit", 32'h0000_0A18, 32'hDEAD_BEEF, 1'b1, 2, 1'b0);
        doWrite("write_miss", 32'h0000_1A18, 32'h1234_5678, 1'b0, 1, 1'b0);
        doRead("read_after_wmiss", 32'h0000_1A18, 1'b0, 2);
        doRead("conflict_a", 32'h0000_0A14, 1'b0, 1);
        doRead("conflict_b", 32'h0000_1A14, 1'b0, 2);
        doRead("conflict_a_again", 32'h0000_0A14, 1'b0, 1);
        doWrite("rd_wr_both", 32'h0000_0A14, 32'hCAFE_F00D, 1'b1, 1, 1'b1);
        idleCycle("stray_ready", 1'b1);
        doRead("hit_after_stray", 32'h0000_0A14, 1'b1, 0);

        // Reset lands mid RD_WAIT while memory is completing: no fill, MsRead drops at once.
        applyStimulus(1'b1, 1'b0, 32'h0000_2040, 32'h0, 1'b0);
        expQ.push_back(mkOut(1'b1, 1'b0, 1'b0, 32'h0000_2040, 1'b0, 1'b0, 32'h0, 32'h0));
        sampleCycle("rst_mid:req");
        for (int k = 1; k <= 2; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0000_2040, 32'h0, 1'b0);
            expQ.push_back(mkOut(1'b1, 1'b0, 1'b0, 32'h0000_2040, 1'b1, 1'b0,
                                 32'h0000_2040, 32'h0));
            sampleCycle("rst_mid:rdwait");
        end
        #1;
        rstN = 1'b0;
        bus.MsReady = 1'b1;
        #1;
        expQ.push_back(mkOut(1'b1, 1'b0, 1'b0, 32'h0000_2040, 1'b0, 1'b0, 32'h0, 32'h0));
        compareCycle("rst_mid:async");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expQ.push_back(mkOut(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0));
        sampleCycle("rst_mid:held");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        doRead("read_after_reset", 32'h0000_0A14, 1'b0, 1);
        doRead("line4_after_reset", 32'h0000_2040, 1'b0, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
